// File: rtl/lcd_sequencer_if.sv
// rtl/lcd_sequencer_if.sv - user write port and LCD controller handshake of lcd_sequencer
interface lcd_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       init_done;
  logic       timeout;
  logic       lcd_start;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       lcd_done;

  modport master (
    output wr_valid, wr_rs, wr_data, lcd_done,
    input  wr_ready, init_done, timeout, lcd_start, lcd_rs, lcd_data
  );

  modport slave (
    input  wr_valid, wr_rs, wr_data, lcd_done,
    output wr_ready, init_done, timeout, lcd_start, lcd_rs, lcd_data
  );
endinterface

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780-style power-up init and user write sequencer
// One shared down-counter times power-up delay, lcd_done timeout and post-command settle.
module lcd_sequencer #(
  parameter int POWERUP_CYCLES = 16,
  parameter int CMD_DELAY      = 4,
  parameter int CLEAR_DELAY    = 32,
  parameter int DONE_TIMEOUT   = 64
) (
  input logic         clk,
  input logic         reset,
  lcd_sequencer_if.slave bus
);

  localparam logic [2:0] S_PWRUP     = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_IDLE      = 3'd4;

  logic [2:0]  state;
  logic [15:0] count;
  logic [1:0]  init_idx;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        init_done_q;
  logic        timeout_q;
  logic        slow_cmd;
  logic [15:0] settle_len;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Clear and home need the long settle regardless of whether init or the user issued them.
  assign slow_cmd   = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
  assign settle_len = slow_cmd ? 16'(CLEAR_DELAY) : 16'(CMD_DELAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PWRUP;
      count       <= 16'(POWERUP_CYCLES);
      init_idx    <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (count <= 16'd1) begin
            state    <= S_ISSUE;
            init_idx <= 2'd0;
            rs_q     <= 1'b0;
            data_q   <= init_byte(2'd0);
          end else begin
            count <= count - 16'd1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_DONE;
          count <= 16'(DONE_TIMEOUT);
        end
        S_WAIT_DONE: begin
          // A done arriving on the expiry cycle wins over the timeout.
          if (bus.lcd_done) begin
            state <= S_SETTLE;
            count <= settle_len;
          end else if (count <= 16'd1) begin
            timeout_q <= 1'b1;
            state     <= S_SETTLE;
            count     <= settle_len;
          end else begin
            count <= count - 16'd1;
          end
        end
        S_SETTLE: begin
          if (count <= 16'd1) begin
            if (init_done_q) begin
              state <= S_IDLE;
            end else if (init_idx == 2'd3) begin
              init_done_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
              init_idx <= init_idx + 2'd1;
              rs_q     <= 1'b0;
              data_q   <= init_byte(init_idx + 2'd1);
              state    <= S_ISSUE;
            end
          end else begin
            count <= count - 16'd1;
          end
        end
        S_IDLE: begin
          if (bus.wr_valid) begin
            rs_q   <= bus.wr_rs;
            data_q <= bus.wr_data;
            state  <= S_ISSUE;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

  assign bus.wr_ready  = (state == S_IDLE);
  assign bus.lcd_start = (state == S_ISSUE);
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_data  = data_q;
  assign bus.init_done = init_done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer
module tb_lcd_sequencer;

  localparam int PU  = 16;
  localparam int CD  = 4;
  localparam int CLD = 32;
  localparam int TO  = 64;

  logic clk;
  logic reset;
  lcd_sequencer_if bus();

  lcd_sequencer #(
    .POWERUP_CYCLES(PU),
    .CMD_DELAY(CD),
    .CLEAR_DELAY(CLD),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit exp_timeout   = 1'b0;
  bit exp_init_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.lcd_done = 1'b0;
  endtask

  function automatic int settle_of(input bit rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLD : CD;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_start", bus.lcd_start, 1'b0);
    check("rst_rs", bus.lcd_rs, 1'b0);
    check("rst_data", bus.lcd_data, 8'h00);
    check("rst_ready", bus.wr_ready, 1'b0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_timeout", bus.timeout, 1'b0);
    reset = 1'b0;
    exp_timeout   = 1'b0;
    exp_init_done = 1'b0;
  endtask

  // Waits for a start, then follows one transfer through WAIT_DONE and SETTLE.
  // lat = cycles from start to the controller's done; 0 means the controller never answers.
  task automatic run_txn(input bit rs, input logic [7:0] d, input int lat,
                         input int exp_start, input bit junk, output int end_cyc);
    int  s;
    int  done_cyc;
    int  guard;
    bit  done_ok;
    guard = 0;
    while (bus.lcd_start !== 1'b1 && guard < 5000) begin
      tick();
      guard++;
      if ($urandom_range(0, 3) == 0) bus.lcd_done = 1'b1;
    end
    check("start_cycle", cyc, exp_start);
    check("start_rs", bus.lcd_rs, rs);
    check("start_data", bus.lcd_data, d);
    check("start_ready", bus.wr_ready, 1'b0);
    s        = cyc;
    done_ok  = (lat > 0 && lat <= TO);
    done_cyc = done_ok ? s + lat : s + TO;
    end_cyc  = done_cyc + settle_of(rs, d);
    while (cyc < end_cyc) begin
      tick();
      if (lat > 0 && cyc == s + lat) bus.lcd_done = 1'b1;
      else if (cyc > done_cyc && $urandom_range(0, 3) == 0) bus.lcd_done = 1'b1;
      if (junk) begin
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_rs    = 1'($urandom_range(0, 1));
        bus.wr_data  = 8'($urandom);
      end
      if (!done_ok && cyc > s + TO) exp_timeout = 1'b1;
      check("busy_start", bus.lcd_start, 1'b0);
      check("busy_rs", bus.lcd_rs, rs);
      check("busy_data", bus.lcd_data, d);
      check("busy_ready", bus.wr_ready, 1'b0);
      check("busy_timeout", bus.timeout, exp_timeout);
      check("busy_init_done", bus.init_done, exp_init_done);
    end
  endtask

  task automatic run_init(input int l0, input int l1, input int l2, input int l3, input int first);
    logic [7:0] tbl [4];
    int lats [4];
    int exp;
    int e;
    tbl[0] = 8'h38; tbl[1] = 8'h0C; tbl[2] = 8'h01; tbl[3] = 8'h06;
    lats[0] = l0; lats[1] = l1; lats[2] = l2; lats[3] = l3;
    exp = first;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, tbl[i], lats[i], exp, 1'b0, e);
      exp = e + 1;
    end
    exp_init_done = 1'b1;
    tick();
    check("init_done", bus.init_done, 1'b1);
    check("init_ready", bus.wr_ready, 1'b1);
    check("init_timeout", bus.timeout, exp_timeout);
  endtask

  task automatic user_write(input bit rs, input logic [7:0] d, input int lat);
    int exp;
    int e;
    check("uw_ready", bus.wr_ready, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_rs    = rs;
    bus.wr_data  = d;
    exp = cyc + 1;
    tick();
    bus.wr_valid = 1'b0;
    run_txn(rs, d, lat, exp, 1'b1, e);
    bus.wr_valid = 1'b0;
    tick();
    check("uw_ready_back", bus.wr_ready, 1'b1);
    check("uw_hold_data", bus.lcd_data, d);
  endtask

  initial begin
    bit         rs;
    logic [7:0] d;
    int         lat;
    int         r;
    int         e;
    int         guard;

    reset        = 1'b1;
    bus.lcd_done = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_rs    = 1'b1;
    bus.wr_data  = 8'h55;

    // Init with a write request held pending the whole time.
    do_reset();
    run_init(3, 3, 3, 3, cyc + PU);
    run_txn(1'b1, 8'h55, 3, cyc + 1, 1'b1, e);
    bus.wr_valid = 1'b0;
    tick();
    check("pend_ready_back", bus.wr_ready, 1'b1);

    // Directed user writes, including clear/home delays and done-at-expiry.
    user_write(1'b1, 8'h41, 3);
    user_write(1'b0, 8'h02, 3);
    user_write(1'b1, 8'h02, 3);
    user_write(1'b0, 8'h01, TO);
    check("no_timeout_at_expiry", bus.timeout, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rs = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 3);
      d  = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom);
      r  = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 12);
      user_write(rs, d, lat);
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) begin
        tick();
        check("gap_ready", bus.wr_ready, 1'b1);
        check("gap_start", bus.lcd_start, 1'b0);
      end
    end

    // Reset while waiting on the 0x0C command's done.
    do_reset();
    run_txn(1'b0, 8'h38, 3, cyc + PU, 1'b0, e);
    guard = 0;
    while (bus.lcd_start !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_start_cycle", cyc, e + 1);
    check("mid_start_data", bus.lcd_data, 8'h0C);
    tick();
    do_reset();

    // Rerun init with the controller silent on 0x0C.
    run_init(3, 0, 3, 3, cyc + PU);
    check("timeout_sticky", bus.timeout, 1'b1);
    user_write(1'b1, 8'h33, 2);
    check("timeout_still", bus.timeout, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter POWERUP_CYCLES, default 16: idle cycles after reset before the first init command.
REQ-002 Parameter CMD_DELAY, default 4: settle cycles after lcd_done for ordinary commands and data.
REQ-003 Parameter CLEAR_DELAY, default 32: settle cycles after lcd_done for clear (0x01) and home (0x02) commands.
REQ-004 Parameter DONE_TIMEOUT, default 64: maximum cycles to wait for lcd_done.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr_valid  input  1  user write request.
REQ-008 wr_rs  input  1  user register select (0 = command, 1 = data).
REQ-009 wr_data  input  8  user byte.
REQ-010 wr_ready  output  1  sequencer accepts a write this cycle.
REQ-011 init_done  output  1  power-up init sequence complete.
REQ-012 timeout  output  1  sticky flag; an lcd_done wait expired.
REQ-013 lcd_start  output  1  one-cycle start pulse to the LCD controller.
REQ-014 lcd_rs  output  1  RS to the LCD controller.
REQ-015 lcd_data  output  8  byte to the LCD controller.
REQ-016 lcd_done  input  1  one-cycle completion pulse from the LCD controller.

Function
REQ-017 FSM states: PWRUP, ISSUE, WAIT_DONE, SETTLE, IDLE; one shared 16-bit down-counter serves power-up, timeout and settle timing.
REQ-018 PWRUP lasts exactly POWERUP_CYCLES cycles, then enters ISSUE with init index 0.
REQ-019 Init table, in order, all with RS=0: 0x38, 0x0C, 0x01, 0x06.
REQ-020 ISSUE lasts exactly one cycle, with lcd_start=1; lcd_start is 0 in every other state.
REQ-021 lcd_rs/lcd_data are registered and stable from the ISSUE cycle through the end of SETTLE, because the controller samples them combinationally until done.
REQ-022 WAIT_DONE exits to SETTLE on the first cycle lcd_done=1.
REQ-023 WAIT_DONE exits to SETTLE after DONE_TIMEOUT cycles without lcd_done, and sets timeout=1; timeout holds until reset.
REQ-024 lcd_done outside WAIT_DONE is ignored.
REQ-025 SETTLE lasts CLEAR_DELAY cycles when the issued byte had RS=0 and data 0x01 or 0x02; otherwise it lasts CMD_DELAY cycles.
REQ-026 After SETTLE during init, the sequencer issues the next table entry.
REQ-027 After SETTLE of the fourth init entry, init_done is set (and stays 1 until reset) and the FSM enters IDLE.
REQ-028 After SETTLE of a user write, the FSM returns to IDLE.
REQ-029 wr_ready = 1 only in IDLE.
REQ-030 A write is accepted when wr_valid & wr_ready; wr_rs/wr_data are captured on that edge, and the next state is ISSUE.
REQ-031 While wr_ready=0, wr_valid is ignored and nothing is queued.
REQ-032 Back-to-back user writes: minimum spacing between accepts = 1 (ISSUE) + wait + settle + 1 (IDLE) cycles.
REQ-033 User-issued 0x01/0x02 with RS=0 receive CLEAR_DELAY, the same as in init.
REQ-034 lcd_done on the same cycle as the timeout expiry counts as done; timeout is not set.

Reset
REQ-035 While reset=1 at a clock edge: state=PWRUP, counter=POWERUP_CYCLES, init index=0, lcd_start=0, lcd_rs=0, lcd_data=0x00, wr_ready=0, init_done=0, timeout=0.
REQ-036 Reset asserted mid-operation (any state) aborts the current transfer on that edge with no further lcd_start pulses, then reruns the full init sequence.

Verification
REQ-037 Release reset with the controller model returning lcd_done 3 cycles after start -> first lcd_start exactly 16 cycles after release, carrying 0x38/RS=0; then 0x0C, 0x01, 0x06; the gap after 0x01's done is 32 cycles and the other gaps are 4; then init_done=1 and wr_ready=1.
REQ-038 After init, wr_valid=1, wr_rs=1, wr_data=0x41 for one cycle -> next cycle lcd_start=1, lcd_rs=1, lcd_data=0x41, held until SETTLE ends; wr_ready=0 throughout and returns to 1 after 4 settle cycles.
REQ-039 wr_valid held high during init with data 0x55 -> no 0x55 ever reaches lcd_data before init_done; the first accept occurs on the first IDLE cycle.
REQ-040 Controller model never returns lcd_done -> timeout=1 exactly 64 cycles into WAIT_DONE; the sequence proceeds to the next command; timeout stays 1.
REQ-041 Assert reset for one cycle in WAIT_DONE of the 0x0C command -> outputs reach reset values; lcd_start reappears 16 cycles later with 0x38.
REQ-042 User write RS=0, data 0x02 -> settle is 32 cycles; user write RS=1, data 0x02 -> settle is 4 cycles.
